req_encoder_q: RTL
==================

Name: req_encoder_q

Overview:
- Sequential inverse of the 4-to-16 Decoder: accepts a 16-bit request vector (bit n = code n) and returns 4-bit codes, one per valid/ready handshake.
- Request pulses are held as sticky pending bits.
- Pending codes are served lowest index first.
- Sits between one-hot event sources (interrupt/strobe lines) and a consumer that wants binary indices; output can loop back through Decoder for checking.

Parameters:
- N_IN, 16, number of request lines (power of two, 2..64).
- IDX_W, $clog2(N_IN) = 4, width of the output code; derived, do not override.

Ports:
- Clk  input  1  single clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Req  input  N_IN  request strobes; bit n high for one or more cycles sets pending[n].
- Clr  input  1  synchronous flush of all pending bits, the output and Overrun.
- Out_Idx  output  IDX_W  served code, registered.
- Out_Valid  output  1  Out_Idx holds a code awaiting acceptance.
- Out_Ready  input  1  consumer accepts; handshake = Out_Valid & Out_Ready at a rising edge.
- Pending  output  N_IN  current pending register, including the code being presented.
- Overrun  output  1  sticky; a request hit an already-pending bit that was not being served.

Behaviour:
- Reset (async, Rst=1) values:
  - Pending = 0, Out_Idx = 0, Out_Valid = 0, Overrun = 0, state = IDLE.
  - Outputs hold these values while Rst is high.
- Pending update every edge: Pending <= (Pending & ~served) | Req.
  - served = onehot(Out_Idx) on handshake, else 0.
  - Req wins over served for the same bit: that bit stays pending and is served again later; not an overrun.
- Overrun:
  - Set when any bit n has Req[n]=1, Pending[n]=1 and bit n is not served this cycle.
  - Cleared only by Rst or Clr.
- State IDLE:
  - If Pending != 0, load Out_Idx = lowest set index of Pending, set Out_Valid = 1, go to PRESENT.
  - Otherwise stay in IDLE; Out_Idx keeps its last value.
- State PRESENT:
  - Out_Idx and Out_Valid are stable until handshake. A newly arrived lower index does not preempt.
  - On handshake, compute rem = Pending & ~served (current Req excluded).
  - If rem != 0: load the lowest index of rem, keep Out_Valid = 1, stay in PRESENT (back-to-back).
  - If rem == 0: Out_Valid <= 0, go to IDLE.
- Latency and throughput:
  - Req at edge k -> Pending at edge k -> Out_Valid at edge k+1, if idle.
  - Throughput is one code per cycle while Out_Ready is held high.
- Clr:
  - Has priority over Req and handshake: Pending <= 0, Overrun <= 0, Out_Valid <= 0, state IDLE.
  - Req asserted in the same cycle as Clr is discarded.
  - Clr while Out_Valid=1 with no handshake drops the code; this is a flush.
- Out_Ready while Out_Valid=0 is ignored.
- All requests simultaneously (Req = 16'hFFFF once): codes 0..15 are emitted in order, with no loss and no duplicates.

Decomposition:
- Shared package holds:
  - N_IN and IDX_W defaults.
  - State enum {IDLE, PRESENT}.
  - Function onehot(idx) returning N_IN bits, shared with Decoder checks.
- One sub-module, lsb_find: combinational lowest-set-bit finder.
  - Input: N_IN-bit vector.
  - Outputs: IDX_W index and 1-bit any.
  - Instantiated twice: once on Pending (IDLE path), once on rem (PRESENT path).

Test Plan:
- Reset mid-operation: Pending = 16'h00F0, Out_Valid = 1; assert Rst asynchronously between edges -> all outputs 0 immediately, with no further codes after release.
- Single request: Out_Ready=1; Req = 16'h0020 for one cycle -> Out_Valid at the next edge with Out_Idx = 5, deasserted one cycle later; Pending returns to 0.
- Priority and back-to-back: Req = 16'h8421 once, Out_Ready held 1 -> Out_Idx sequence 0, 5, 10, 15 on consecutive cycles, then Out_Valid = 0.
- Backpressure and no preemption: Out_Ready = 0, Req = 16'h0010, then Req = 16'h0001 two cycles later -> Out_Idx stays 4. Raise Out_Ready -> codes 4 then 0.
- Overrun vs re-arm:
  - Out_Ready = 0; Req = 16'h0008 twice -> Overrun = 1.
  - After Clr, present code 3 with Out_Ready = 1 and Req = 16'h0008 in the same cycle -> Overrun stays 0; code 3 is emitted again next cycle.
- Clr flush: Pending = 16'hFFFF, Out_Valid = 1, Clr = 1 with Req = 16'h0002 -> next cycle Pending = 0, Out_Valid = 0, Overrun = 0; no code 1 is emitted afterwards.

Source files
------------

// File: rtl/req_encoder_q_pkg.sv
// req_encoder_q_pkg: shared sizes, FSM state type and one-hot decode helper for req_encoder_q
package req_encoder_q_pkg;
  localparam int N_IN_DEF  = 16;
  localparam int IDX_W_DEF = $clog2(N_IN_DEF);
  typedef enum logic {IDLE, PRESENT} state_t;
  function automatic logic [N_IN_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
    return N_IN_DEF'(1) << idx;
  endfunction
endpackage

// File: rtl/req_encoder_q_lsb_find.sv
// lsb_find: combinational lowest-set-bit finder
//   vec : input vector
//   idx : index of the lowest set bit (0 when vec is empty)
//   any : vec has at least one bit set
module lsb_find #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) idx = W'(i);
  end
  assign any = |vec;
endmodule

// File: rtl/req_encoder_q.sv
// req_encoder_q: sticky one-hot request collector serving binary codes lowest index first over valid/ready
//   Clk, Rst      : rising-edge clock, asynchronous active-high reset
//   Req           : request strobes, each sets its pending bit
//   Clr           : synchronous flush of pending bits, output and Overrun
//   Out_Idx       : presented code (registered)
//   Out_Valid     : Out_Idx awaits acceptance
//   Out_Ready     : consumer accepts on Out_Valid & Out_Ready
//   Pending       : pending register, including the presented code
//   Overrun       : sticky, a request hit an already-pending unserved bit
module req_encoder_q import req_encoder_q_pkg::*; #(
  parameter int N_IN  = N_IN_DEF,
  localparam int IDX_W = $clog2(N_IN)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_IN-1:0]  Req,
  input  logic             Clr,
  output logic [IDX_W-1:0] Out_Idx,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [N_IN-1:0]  Pending,
  output logic             Overrun
);
  state_t           state, state_d;
  logic [IDX_W-1:0] idx_d, p_idx, r_idx;
  logic             valid_d, p_any, r_any, hs;
  logic [N_IN-1:0]  served, rem;
  assign hs     = Out_Valid & Out_Ready;
  assign served = hs ? N_IN'(1) << Out_Idx : '0;
  assign rem    = Pending & ~served;
  lsb_find #(.N(N_IN), .W(IDX_W)) u_find_pend (.vec(Pending), .idx(p_idx), .any(p_any));
  lsb_find #(.N(N_IN), .W(IDX_W)) u_find_rem  (.vec(rem),     .idx(r_idx), .any(r_any));
  always_comb begin
    state_d = state;
    idx_d   = Out_Idx;
    valid_d = Out_Valid;
    if (Clr) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else if (state == IDLE) begin
      if (p_any) begin
        state_d = PRESENT;
        idx_d   = p_idx;
        valid_d = 1'b1;
      end
    end else if (hs) begin
      // back-to-back service from what remains; same-cycle Req waits for the next scan
      if (r_any) idx_d = r_idx;
      else begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    end
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state     <= IDLE;
      Out_Idx   <= '0;
      Out_Valid <= 1'b0;
      Pending   <= '0;
      Overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      Out_Idx   <= idx_d;
      Out_Valid <= valid_d;
      Pending   <= Clr ? '0 : rem | Req;
      // re-arming the bit being served is not an overrun
      Overrun   <= Clr ? 1'b0 : Overrun | (|(Req & rem));
    end
endmodule
